// File: rtl/rv32i_load_store_unit_if.sv
// Load/store unit bus bundle: datapath request/response, stall flag and the
// data-memory request channel. The slave modport is the unit itself; the
// master modport is the surrounding datapath plus data memory.
interface rv32i_load_store_unit_if;
  // Datapath request
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Response back to write-back
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic        busy;
  // Data-memory channel
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, busy,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, busy,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/rv32i_load_store_unit.sv
// RV32I load/store unit. Accepts one load or store at a time from the
// datapath, screens it for illegal funct3 and misalignment, issues a single
// word-aligned data-memory request with byte enables, waits for the ack (or
// times out) and returns one response strobe with extended load data.
module rv32i_load_store_unit #(
  parameter int ACK_TIMEOUT = 255   // memory-wait cycles before timeout, 1..255
) (
  input logic                    clock,
  input logic                    reset,
  rv32i_load_store_unit_if.slave lsu
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);

  localparam logic [1:0] FAULT_OK        = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN  = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT   = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MEM  = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;        // low address bits select the load byte lane
  logic        r_write;
  logic [7:0]  r_cnt;         // MEM cycles seen without an ack
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic [1:0]  r_resp_fault;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic        w_timeout;

  assign w_accept  = lsu.req_valid && (r_state == IDLE);
  assign w_timeout = (r_cnt == TIMEOUT_LAST);

  // Legal encodings: loads LB/LH/LW/LBU/LHU, stores SB/SH/SW only.
  always_comb begin
    w_illegal = 1'b1;
    case (lsu.req_funct3)
      3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
      3'b100, 3'b101:         w_illegal = lsu.req_write;
      default:                w_illegal = 1'b1;
    endcase
  end

  // Halfwords need an even address, words a multiple of four.
  always_comb begin
    w_misaligned = 1'b0;
    case (lsu.req_funct3[1:0])
      2'b01:   w_misaligned = lsu.req_addr[0];
      2'b10:   w_misaligned = (lsu.req_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data; loads always read the full word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = lsu.req_wdata;
    if (lsu.req_write) begin
      case (lsu.req_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << lsu.req_addr[1:0];
          w_wdata = {4{lsu.req_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = lsu.req_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{lsu.req_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = lsu.req_wdata;
        end
      endcase
    end
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    case (r_lane)
      2'b00:   w_byte = lsu.mem_rdata[7:0];
      2'b01:   w_byte = lsu.mem_rdata[15:8];
      2'b10:   w_byte = lsu.mem_rdata[23:16];
      default: w_byte = lsu.mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? lsu.mem_rdata[31:16] : lsu.mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = lsu.mem_rdata;
    endcase
  end

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_funct3     <= 3'd0;
      r_lane       <= 2'd0;
      r_write      <= 1'b0;
      r_cnt        <= 8'd0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_be     <= 4'd0;
      r_mem_wdata  <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_fault <= FAULT_OK;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_funct3 <= lsu.req_funct3;
            r_lane   <= lsu.req_addr[1:0];
            r_write  <= lsu.req_write;
            r_cnt    <= 8'd0;
            if (w_illegal || w_misaligned) begin
              // Faulted at accept: answer next cycle without touching memory.
              r_resp_valid <= 1'b1;
              r_resp_rdata <= 32'd0;
              r_resp_fault <= w_illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
              r_state      <= RESP;
            end else begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= lsu.req_write;
              r_mem_addr  <= {lsu.req_addr[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_state     <= MEM;
            end
          end
        end
        MEM: begin
          // An ack on the final allowed cycle still completes normally.
          if (lsu.mem_ack) begin
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_write ? 32'd0 : w_load_data;
            r_resp_fault <= FAULT_OK;
            r_state      <= RESP;
          end else if (w_timeout) begin
            r_mem_req    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= 32'd0;
            r_resp_fault <= FAULT_TIMEOUT;
            r_state      <= RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          // Single-cycle strobe; response fields return to zero with it.
          r_resp_valid <= 1'b0;
          r_resp_rdata <= 32'd0;
          r_resp_fault <= FAULT_OK;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign lsu.req_ready  = (r_state == IDLE);
  assign lsu.busy       = (r_state != IDLE);
  assign lsu.resp_valid = r_resp_valid;
  assign lsu.resp_rdata = r_resp_rdata;
  assign lsu.resp_fault = r_resp_fault;
  assign lsu.mem_req    = r_mem_req;
  assign lsu.mem_we     = r_mem_we;
  assign lsu.mem_addr   = r_mem_addr;
  assign lsu.mem_be     = r_mem_be;
  assign lsu.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Directed bench for rv32i_load_store_unit with ACK_TIMEOUT = 4. Inputs are
// driven and outputs sampled 1 ns after each rising edge.
module tb_rv32i_load_store_unit;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  rv32i_load_store_unit_if bus ();

  rv32i_load_store_unit #(.ACK_TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .lsu   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
    $display("check %-18s observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Present a request for one cycle; returns just after the accepting edge.
  task automatic send(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    tick();
    bus.req_valid  = 1'b0;
  endtask

  initial begin
    int hi;
    int got;
    int seen;
    logic [1:0] flt;

    n_checks = 0;
    n_fail   = 0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'd0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b0;
    tick();

    // mem_ack outside MEM is ignored
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("stray_ack_valid", 32'(bus.resp_valid), 32'd0);
    chk("stray_ack_busy", 32'(bus.busy), 32'd0);

    // LB 0x1003, ack two cycles after mem_req
    send(1'b0, 3'b000, 32'h0000_1003, 32'd0);
    chk("lb_mem_req", 32'(bus.mem_req), 32'd1);
    chk("lb_mem_be", 32'(bus.mem_be), 32'hF);
    chk("lb_mem_addr", bus.mem_addr, 32'h0000_1000);
    chk("lb_mem_we", 32'(bus.mem_we), 32'd0);
    chk("lb_busy", 32'(bus.busy), 32'd1);
    chk("lb_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("lb_hold_req", 32'(bus.mem_req), 32'd1);
    chk("lb_hold_valid", 32'(bus.resp_valid), 32'd0);
    tick();
    bus.mem_rdata = 32'h80FF_FF00;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    chk("lb_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("lb_resp_rdata", bus.resp_rdata, 32'hFFFF_FF80);
    chk("lb_resp_fault", 32'(bus.resp_fault), 32'd0);
    chk("lb_mem_req_drop", 32'(bus.mem_req), 32'd0);
    chk("lb_resp_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("lb_valid_1cyc", 32'(bus.resp_valid), 32'd0);
    chk("lb_back_idle", 32'(bus.req_ready), 32'd1);

    // SH 0x2002
    send(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD);
    chk("sh_mem_we", 32'(bus.mem_we), 32'd1);
    chk("sh_mem_addr", bus.mem_addr, 32'h0000_2000);
    chk("sh_mem_be", 32'(bus.mem_be), 32'hC);
    chk("sh_mem_wdata", bus.mem_wdata, 32'hABCD_ABCD);
    bus.mem_rdata = 32'hDEAD_BEEF;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    chk("sh_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("sh_resp_rdata", bus.resp_rdata, 32'd0);
    chk("sh_resp_fault", 32'(bus.resp_fault), 32'd0);
    tick();

    // SB 0x3001
    send(1'b1, 3'b000, 32'h0000_3001, 32'h0000_0055);
    chk("sb_mem_be", 32'(bus.mem_be), 32'h2);
    chk("sb_mem_wdata", bus.mem_wdata, 32'h5555_5555);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    chk("sb_resp_valid", 32'(bus.resp_valid), 32'd1);
    tick();

    // LH 0x0002 sign-extended upper half
    send(1'b0, 3'b001, 32'h0000_0002, 32'd0);
    bus.mem_rdata = 32'h8001_1234;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    chk("lh_resp_rdata", bus.resp_rdata, 32'hFFFF_8001);
    tick();

    // LW 0x0006 misaligned
    send(1'b0, 3'b010, 32'h0000_0006, 32'd0);
    chk("lw_mis_mem_req", 32'(bus.mem_req), 32'd0);
    chk("lw_mis_valid", 32'(bus.resp_valid), 32'd1);
    chk("lw_mis_fault", 32'(bus.resp_fault), 32'd1);
    chk("lw_mis_rdata", bus.resp_rdata, 32'd0);
    tick();

    // Store funct3 100 illegal
    send(1'b1, 3'b100, 32'h0000_0000, 32'h1111_1111);
    chk("st100_mem_req", 32'(bus.mem_req), 32'd0);
    chk("st100_valid", 32'(bus.resp_valid), 32'd1);
    chk("st100_fault", 32'(bus.resp_fault), 32'd3);
    tick();

    // Illegal load funct3 with odd address: illegal wins
    send(1'b0, 3'b011, 32'h0000_0001, 32'd0);
    chk("ld011_fault", 32'(bus.resp_fault), 32'd3);
    tick();

    // Timeout: no ack, mem_req high exactly 4 cycles
    send(1'b0, 3'b010, 32'h0000_0040, 32'd0);
    hi  = 0;
    got = 0;
    flt = 2'b00;
    for (int i = 0; i < 10 && got == 0; i++) begin
      if (bus.mem_req) hi++;
      if (bus.resp_valid) begin
        got = 1;
        flt = bus.resp_fault;
      end else begin
        tick();
      end
    end
    chk("to_resp_seen", 32'(got), 32'd1);
    chk("to_req_cycles", 32'(hi), 32'd4);
    chk("to_fault", 32'(flt), 32'd2);
    chk("to_rdata", bus.resp_rdata, 32'd0);
    tick();

    // Ack on the 4th mem_req cycle still completes
    send(1'b0, 3'b010, 32'h0000_0044, 32'd0);
    tick();
    tick();
    tick();
    chk("ack4_req_high", 32'(bus.mem_req), 32'd1);
    bus.mem_rdata = 32'hCAFE_F00D;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    chk("ack4_valid", 32'(bus.resp_valid), 32'd1);
    chk("ack4_fault", 32'(bus.resp_fault), 32'd0);
    chk("ack4_rdata", bus.resp_rdata, 32'hCAFE_F00D);
    tick();

    // Reset while in MEM abandons the transaction
    send(1'b0, 3'b010, 32'h0000_0080, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmem_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rstmem_busy", 32'(bus.busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.resp_valid) seen++;
      tick();
    end
    chk("rstmem_no_resp", 32'(seen), 32'd0);

    // LHU 0x10 after the abandoned transaction
    send(1'b0, 3'b101, 32'h0000_0010, 32'd0);
    bus.mem_rdata = 32'h0000_8001;
    bus.mem_ack   = 1'b1;
    tick();
    bus.mem_ack   = 1'b0;
    chk("lhu_valid", 32'(bus.resp_valid), 32'd1);
    chk("lhu_rdata", bus.resp_rdata, 32'h0000_8001);
    chk("lhu_fault", 32'(bus.resp_fault), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
